// File: rtl/gpgpu_block_ram.sv
// Block-addressed single-port memory model serving tagged reads and byte-enabled writes.
// Latency: a read response is valid in the cycle after the request is accepted.
// Backpressure: the request ready signal drops while the response queue is full; there is no same-cycle pop bypass.
module gpgpu_block_ram #(
  parameter int RAM_ADDR_BITS = 9,
  parameter int DATA_WIDTH    = 512,
  parameter int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  parameter int TAG_WIDTH     = 8,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mem_req_valid_i,
  input  logic                     mem_req_rw_i,
  input  logic [BYTEEN_WIDTH-1:0]  mem_req_byteen_i,
  input  logic [RAM_ADDR_BITS-1:0] mem_req_addr_i,
  input  logic [DATA_WIDTH-1:0]    mem_req_data_i,
  input  logic [TAG_WIDTH-1:0]     mem_req_tag_i,
  output logic                     mem_req_ready_o,
  output logic                     mem_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    mem_rsp_data_o,
  output logic [TAG_WIDTH-1:0]     mem_rsp_tag_o,
  input  logic                     mem_rsp_ready_i
);

  localparam int DEPTH = 1 << RAM_ADDR_BITS;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Backing store; the simulation environment preloads and dumps it hierarchically,
  // so it is deliberately left out of the reset domain.
  logic [DATA_WIDTH-1:0] mem_array [0:DEPTH-1];

  // Response queue storage; contents are only observed through the head when non-empty.
  logic [DATA_WIDTH-1:0] r_q_data [0:RSP_DEPTH-1];
  logic [TAG_WIDTH-1:0]  r_q_tag  [0:RSP_DEPTH-1];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_req_fire;
  logic w_wr_fire;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == CNT_W'(RSP_DEPTH));
  assign w_empty    = (r_count == '0);
  // Ready ignores a pop in the same cycle so the accept path never depends on the consumer.
  assign mem_req_ready_o = rst_ni && !w_full;
  assign w_req_fire = mem_req_valid_i && mem_req_ready_o;
  assign w_wr_fire  = w_req_fire && mem_req_rw_i;
  assign w_push     = w_req_fire && !mem_req_rw_i;
  assign w_pop      = !w_empty && mem_rsp_ready_i;

  assign mem_rsp_valid_o = !w_empty;
  assign mem_rsp_data_o  = w_empty ? '0 : r_q_data[r_rd_ptr];
  assign mem_rsp_tag_o   = w_empty ? '0 : r_q_tag[r_rd_ptr];

  // Byte-enabled write into the addressed block; disabled bytes keep their value.
  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      for (int i = 0; i < BYTEEN_WIDTH; i++) begin
        if (mem_req_byteen_i[i]) begin
          mem_array[mem_req_addr_i][8*i +: 8] <= mem_req_data_i[8*i +: 8];
        end
      end
    end
  end

  // Snapshot the block and tag at acceptance so later writes cannot alter a queued response.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= mem_array[mem_req_addr_i];
      r_q_tag[r_wr_ptr]  <= mem_req_tag_i;
    end
  end

  // Queue pointers and occupancy; reset discards every queued response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_gpgpu_block_ram.sv
// Randomised and directed bench for gpgpu_block_ram against a queue-based reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Reset, preload, byte enables, backpressure, push/pop overlap, snapshot and mid-run reset are covered.
module tb_gpgpu_block_ram;

  localparam int AW = 9;
  localparam int DW = 512;
  localparam int BW = DW / 8;
  localparam int TW = 8;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_rw;
  logic [BW-1:0] req_byteen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready;

  always #5 clk = ~clk;

  gpgpu_block_ram #(
    .RAM_ADDR_BITS(AW),
    .DATA_WIDTH(DW),
    .BYTEEN_WIDTH(BW),
    .TAG_WIDTH(TW),
    .RSP_DEPTH(QD)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .mem_req_valid_i(req_valid),
    .mem_req_rw_i(req_rw),
    .mem_req_byteen_i(req_byteen),
    .mem_req_addr_i(req_addr),
    .mem_req_data_i(req_data),
    .mem_req_tag_i(req_tag),
    .mem_req_ready_o(req_ready),
    .mem_rsp_valid_o(rsp_valid),
    .mem_rsp_data_o(rsp_data),
    .mem_rsp_tag_o(rsp_tag),
    .mem_rsp_ready_i(rsp_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain memory image plus an in-order queue of expected responses.
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] q_data [$];
  logic [TW-1:0] q_tag  [$];
  bit            in_rst;

  function automatic logic [DW-1:0] rand_block();
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (q_data.size() > 0) ? q_data[0] : '0;
  endfunction

  function automatic logic [TW-1:0] exp_tag();
    return (q_tag.size() > 0) ? q_tag[0] : '0;
  endfunction

  // Drive one request/response cycle starting at a falling edge; update the model at the next one.
  task automatic drive(input logic v, input logic rw, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d,
                       input logic [TW-1:0] t, input logic rr);
    bit acc;
    bit pop;
    req_valid  = v;
    req_rw     = rw;
    req_addr   = a;
    req_byteen = be;
    req_data   = d;
    req_tag    = t;
    rsp_ready  = rr;
    acc = v && !in_rst && (q_data.size() < QD);
    pop = !in_rst && (q_data.size() > 0) && rr;
    @(negedge clk);
    if (pop) begin
      void'(q_data.pop_front());
      void'(q_tag.pop_front());
    end
    if (acc) begin
      if (rw) begin
        for (int i = 0; i < BW; i++)
          if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
      end else begin
        q_data.push_back(model_mem[a]);
        q_tag.push_back(t);
      end
    end
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, '0, '0, '0, '0, rr);
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    rst_n = 1'b0; in_rst = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_byteen = '0; req_addr = '0;
    req_data = '0; req_tag = '0; rsp_ready = 1'b0;
    for (int i = 0; i < (1<<AW); i++) begin
      v = rand_block();
      dut.mem_array[i] = v;
      model_mem[i] = v;
    end
    v = {64{8'hA5}};
    dut.mem_array[5] = v;
    model_mem[5] = v;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    n_cmp++; if (rsp_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", rsp_tag); end
    rst_n = 1'b1; in_rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_preload_read();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL preload_pre_valid: got %0b want 0", rsp_valid); end
    drive(1'b1, 1'b0, 9'd5, '0, '0, 8'h3C, 1'b1);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL preload_valid: got %0b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== {64{8'hA5}}) begin n_fail++; $display("FAIL preload_data: got %h want a5..a5", rsp_data); end
    n_cmp++; if (rsp_tag !== 8'h3C) begin n_fail++; $display("FAIL preload_tag: got %h want 3c", rsp_tag); end
    idle(1'b1);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL preload_pulse: got %0b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL preload_empty_data: got %h want 0", rsp_data); end
    n_cmp++; if (rsp_tag !== '0) begin n_fail++; $display("FAIL preload_empty_tag: got %h want 0", rsp_tag); end
  endtask

  task automatic test_byteen_write();
    logic [DW-1:0] e;
    e = '0;
    e[31:0] = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, 9'd7, {BW{1'b1}}, '0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 9'd7, 64'hF, {DW{1'b1}}, 8'h00, 1'b1);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_no_rsp: got %0b want 0", rsp_valid); end
    drive(1'b1, 1'b1, 9'd7, '0, rand_block(), 8'h00, 1'b1);
    drive(1'b1, 1'b0, 9'd7, '0, '0, 8'h77, 1'b1);
    n_cmp++; if (rsp_data !== e) begin n_fail++; $display("FAIL byteen_data: got %h want %h", rsp_data, e); end
    n_cmp++; if (rsp_tag !== 8'h77) begin n_fail++; $display("FAIL byteen_tag: got %h want 77", rsp_tag); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %0b want 1", i, req_ready); end
      drive(1'b1, 1'b0, AW'(i), '0, '0, TW'(i), 1'b0);
    end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0b want 0", req_ready); end
    drive(1'b1, 1'b0, 9'd31, '0, '0, 8'hDD, 1'b0);
    n_cmp++; if (rsp_tag !== 8'd1) begin n_fail++; $display("FAIL bp_stable_tag: got %h want 01", rsp_tag); end
    n_cmp++; if (rsp_data !== model_mem[1]) begin n_fail++; $display("FAIL bp_head_data: got %h want %h", rsp_data, model_mem[1]); end
    drive(1'b1, 1'b0, 9'd30, '0, '0, 8'hEE, 1'b1);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reassert: got %0b want 1", req_ready); end
    for (int i = 2; i <= 4; i++) begin
      n_cmp++; if (rsp_tag !== TW'(i)) begin n_fail++; $display("FAIL bp_tag_%0d: got %h want %h", i, rsp_tag, TW'(i)); end
      n_cmp++; if (rsp_data !== model_mem[i]) begin n_fail++; $display("FAIL bp_data_%0d: got %h want %h", i, rsp_data, model_mem[i]); end
      idle(1'b1);
    end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_push_pop();
    drive(1'b1, 1'b0, 9'd10, '0, '0, 8'h10, 1'b0);
    drive(1'b1, 1'b0, 9'd11, '0, '0, 8'h11, 1'b0);
    drive(1'b1, 1'b0, 9'd12, '0, '0, 8'h12, 1'b1);
    n_cmp++; if (rsp_tag !== 8'h11) begin n_fail++; $display("FAIL pp_tag_a: got %h want 11", rsp_tag); end
    n_cmp++; if (rsp_data !== model_mem[11]) begin n_fail++; $display("FAIL pp_data_a: got %h want %h", rsp_data, model_mem[11]); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready: got %0b want 1", req_ready); end
    idle(1'b1);
    n_cmp++; if (rsp_tag !== 8'h12) begin n_fail++; $display("FAIL pp_tag_b: got %h want 12", rsp_tag); end
    n_cmp++; if (rsp_data !== model_mem[12]) begin n_fail++; $display("FAIL pp_data_b: got %h want %h", rsp_data, model_mem[12]); end
    idle(1'b1);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL pp_drained: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_snapshot();
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    x = model_mem[9];
    y = rand_block();
    drive(1'b1, 1'b0, 9'd9, '0, '0, 8'h99, 1'b0);
    drive(1'b1, 1'b1, 9'd9, {BW{1'b1}}, y, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 9'd9, '0, '0, 8'h9A, 1'b0);
    n_cmp++; if (rsp_tag !== 8'h99) begin n_fail++; $display("FAIL snap_tag_old: got %h want 99", rsp_tag); end
    n_cmp++; if (rsp_data !== x) begin n_fail++; $display("FAIL snap_data_old: got %h want %h", rsp_data, x); end
    idle(1'b1);
    n_cmp++; if (rsp_tag !== 8'h9A) begin n_fail++; $display("FAIL snap_tag_new: got %h want 9a", rsp_tag); end
    n_cmp++; if (rsp_data !== y) begin n_fail++; $display("FAIL snap_data_new: got %h want %h", rsp_data, y); end
    idle(1'b1);
  endtask

  task automatic test_reset_midop();
    logic [DW-1:0] z;
    z = rand_block();
    drive(1'b1, 1'b1, 9'd20, {BW{1'b1}}, z, 8'h00, 1'b1);
    for (int i = 21; i <= 23; i++) drive(1'b1, 1'b0, AW'(i), '0, '0, TW'(i), 1'b0);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %0b want 1", rsp_valid); end
    #2;
    rst_n = 1'b0; in_rst = 1'b1;
    q_data.delete(); q_tag.delete();
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %0b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_ready: got %0b want 0", req_ready); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL mid_async_data: got %h want 0", rsp_data); end
    drive(1'b1, 1'b1, 9'd20, {BW{1'b1}}, rand_block(), 8'h00, 1'b1);
    idle(1'b0);
    rst_n = 1'b1; in_rst = 1'b0;
    drive(1'b1, 1'b0, 9'd20, '0, '0, 8'h20, 1'b1);
    n_cmp++; if (rsp_data !== z) begin n_fail++; $display("FAIL mid_preserved: got %h want %h", rsp_data, z); end
    n_cmp++; if (rsp_tag !== 8'h20) begin n_fail++; $display("FAIL mid_tag: got %h want 20", rsp_tag); end
    idle(1'b1);
  endtask

  task automatic test_random();
    logic [BW-1:0] be;
    for (int n = 0; n < 400; n++) begin
      n_cmp++; if (req_ready !== (q_data.size() < QD)) begin n_fail++; $display("FAIL rnd_ready_%0d: got %0b", n, req_ready); end
      n_cmp++; if (rsp_valid !== (q_data.size() > 0)) begin n_fail++; $display("FAIL rnd_valid_%0d: got %0b", n, rsp_valid); end
      n_cmp++; if (rsp_tag !== exp_tag()) begin n_fail++; $display("FAIL rnd_tag_%0d: got %h want %h", n, rsp_tag, exp_tag()); end
      n_cmp++; if (rsp_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data_%0d: got %h want %h", n, rsp_data, exp_data()); end
      be = {$urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
            be, rand_block(), TW'($urandom()), 1'($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < QD + 2; n++) idle(1'b1);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drained: got %0b want 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_byteen_write();
    test_backpressure();
    test_push_pop();
    test_snapshot();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
